// File: rtl/iob_vexriscv_bus_merge_pkg.sv
// Shared definitions for the VexRiscv ibus/dbus merge: source tags and arbiter states.
package iob_vexriscv_bus_merge_pkg;

    localparam logic IBUS_TAG = 1'b0;
    localparam logic DBUS_TAG = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Packed response layout {rdata, rvalid, ready}
    localparam int RESP_READY_BIT  = 0;
    localparam int RESP_RVALID_BIT = 1;
    localparam int RESP_RDATA_LSB  = 2;

endpackage

// File: rtl/iob_vexriscv_tag_fifo.sv
// Register-based 1-bit tag FIFO recording which bus issued each outstanding read.
module iob_vexriscv_tag_fifo
    import iob_vexriscv_bus_merge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic cke_i,
    input  logic push_i,
    input  logic tag_i,
    input  logic pop_i,
    output logic head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] tags_q, tags_d;
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = tags_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        tags_d = tags_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            tags_d[wptr_q] = tag_i;
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (do_pop) rptr_d = rptr_q + PTR_W'(1);
        if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tags_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (cke_i) begin
            tags_q <= tags_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/iob_vexriscv_bus_merge.sv
// Merges VexRiscv ibus/dbus IOb native ports onto one memory port with
// round-robin arbitration, hold-until-accepted, and tag-routed read responses.
module iob_vexriscv_bus_merge
    import iob_vexriscv_bus_merge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MAX_RD = 4,
    parameter int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
    parameter int RESP_W = DATA_W + 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cke_i,
    input  logic [REQ_W-1:0]  ibus_req_i,
    output logic [RESP_W-1:0] ibus_resp_o,
    input  logic [REQ_W-1:0]  dbus_req_i,
    output logic [RESP_W-1:0] dbus_resp_o,
    output logic [REQ_W-1:0]  mem_req_o,
    input  logic [RESP_W-1:0] mem_resp_i,
    output logic              err_o
);
    localparam int STRB_W     = DATA_W / 8;
    localparam int AVALID_BIT = REQ_W - 1;

    state_e           state_q, state_d;
    logic             hold_src_q, hold_src_d;
    logic             last_q, last_d;
    logic             err_q, err_d;
    logic             grant, req_vld, is_read, blocked;
    logic             mem_avalid, mem_ready, accept, rdy_gnt;
    logic             rvalid_in, fifo_push, fifo_pop, fifo_head, fifo_full, fifo_empty;
    logic [REQ_W-1:0] sel_req;

    always_comb begin
        grant = IBUS_TAG;
        if (state_q == ST_HOLD) grant = hold_src_q;
        else if (ibus_req_i[AVALID_BIT] && dbus_req_i[AVALID_BIT]) grant = ~last_q;
        else if (dbus_req_i[AVALID_BIT]) grant = DBUS_TAG;
    end

    assign sel_req    = (grant == DBUS_TAG) ? dbus_req_i : ibus_req_i;
    assign req_vld    = sel_req[AVALID_BIT] & rst_n_i;
    assign is_read    = (sel_req[STRB_W-1:0] == '0);
    // A read may not issue while the tag FIFO is full; writes need no tag.
    assign blocked    = is_read & fifo_full;
    assign mem_ready  = mem_resp_i[RESP_READY_BIT];
    assign mem_avalid = req_vld & ~blocked & cke_i;
    assign accept     = mem_avalid & mem_ready;
    assign rdy_gnt    = accept;
    assign mem_req_o  = req_vld ? {mem_avalid, sel_req[AVALID_BIT-1:0]} : '0;

    always_comb begin
        state_d    = state_q;
        hold_src_d = hold_src_q;
        last_d     = last_q;
        if (req_vld) begin
            if (accept) begin
                last_d  = grant;
                state_d = ST_IDLE;
            end else begin
                state_d    = ST_HOLD;
                hold_src_d = grant;
            end
        end
    end

    assign rvalid_in = mem_resp_i[RESP_RVALID_BIT] & cke_i & rst_n_i;
    assign fifo_push = accept & is_read;
    assign fifo_pop  = rvalid_in & ~fifo_empty;
    assign err_d     = err_q | (rvalid_in & fifo_empty);
    assign err_o     = err_q;

    assign ibus_resp_o = {mem_resp_i[RESP_W-1:RESP_RDATA_LSB],
                          fifo_pop & (fifo_head == IBUS_TAG),
                          rdy_gnt & (grant == IBUS_TAG)};
    assign dbus_resp_o = {mem_resp_i[RESP_W-1:RESP_RDATA_LSB],
                          fifo_pop & (fifo_head == DBUS_TAG),
                          rdy_gnt & (grant == DBUS_TAG)};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            hold_src_q <= IBUS_TAG;
            last_q     <= IBUS_TAG;
            err_q      <= 1'b0;
        end else if (cke_i) begin
            state_q    <= state_d;
            hold_src_q <= hold_src_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    iob_vexriscv_tag_fifo #(.DEPTH(MAX_RD)) u_tag_fifo (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .cke_i  (cke_i),
        .push_i (fifo_push),
        .tag_i  (grant),
        .pop_i  (fifo_pop),
        .head_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

endmodule

// File: tb/tb_iob_vexriscv_bus_merge.sv
// Bench for iob_vexriscv_bus_merge: directed vector table, corner sequences, random traffic vs. a queue model.
module tb_iob_vexriscv_bus_merge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MAX_RD = 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RESP_W = DATA_W + 2;
    localparam int ADDR_LSB = STRB_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cke = 1'b1;
    logic [REQ_W-1:0]  ireq = '0, dreq = '0, mreq;
    logic [RESP_W-1:0] iresp, dresp, mresp = '0;
    logic              err;

    always #5 clk = ~clk;

    iob_vexriscv_bus_merge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD(MAX_RD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke),
        .ibus_req_i(ireq), .ibus_resp_o(iresp),
        .dbus_req_i(dreq), .dbus_resp_o(dresp),
        .mem_req_o(mreq), .mem_resp_i(mresp), .err_o(err)
    );

    int total = 0, bad = 0;

    function automatic logic [REQ_W-1:0] mkreq(input logic av, input logic [ADDR_W-1:0] a,
                                               input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
        return {av, a, d, s};
    endfunction
    function automatic logic [REQ_W-1:0] rd(input logic [ADDR_W-1:0] a);
        return mkreq(1'b1, a, '0, '0);
    endfunction
    function automatic logic [RESP_W-1:0] rs(input logic [DATA_W-1:0] d, input logic v, input logic r);
        return {d, v, r};
    endfunction

    task automatic chk(input string name, input logic [REQ_W-1:0] act, input logic [REQ_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, last winner, queue of outstanding read sources, sticky error.
    bit m_lock, m_src, m_last, m_err;
    bit m_q[$];
    bit e_have, e_g, e_rd, e_mav, e_acc, e_rv;
    logic [REQ_W-1:0]  e_mreq;
    logic [RESP_W-1:0] e_iresp, e_dresp;

    task automatic model_eval();
        logic [REQ_W-1:0] r;
        bit iv, dv, blk, hit, head;
        iv = ireq[REQ_W-1];
        dv = dreq[REQ_W-1];
        if (m_lock) e_g = m_src;
        else if (iv && dv) e_g = !m_last;
        else e_g = dv;
        r      = e_g ? dreq : ireq;
        e_have = rst_n && r[REQ_W-1];
        e_rd   = (r[STRB_W-1:0] == '0);
        blk    = e_rd && (m_q.size() == MAX_RD);
        e_mav  = e_have && !blk && cke;
        e_acc  = e_mav && mresp[0];
        e_mreq = e_have ? {e_mav, r[REQ_W-2:0]} : '0;
        e_rv   = rst_n && cke && mresp[1];
        hit    = e_rv && (m_q.size() > 0);
        head   = hit ? m_q[0] : 1'b0;
        e_iresp = {mresp[RESP_W-1:2], hit && !head, e_acc && !e_g};
        e_dresp = {mresp[RESP_W-1:2], hit && head, e_acc && e_g};
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_lock = 0; m_last = 0; m_err = 0; m_q.delete();
        end else if (cke) begin
            if (e_rv) begin
                if (m_q.size() > 0) void'(m_q.pop_front());
                else m_err = 1;
            end
            if (e_have) begin
                if (e_acc) begin
                    m_last = e_g; m_lock = 0;
                    if (e_rd) m_q.push_back(e_g);
                end else begin
                    m_lock = 1; m_src = e_g;
                end
            end
        end
    endtask

    typedef struct {
        logic [REQ_W-1:0]  ireq, dreq;
        logic [RESP_W-1:0] mresp;
        logic [REQ_W-1:0]  emreq;
        logic [RESP_W-1:0] eiresp, edresp;
    } vec_t;
    vec_t tbl[22];
    int tidx = -1;

    task automatic sample();
        @(negedge clk);
        model_eval();
        chk("mem_req", mreq, e_mreq);
        chk("ibus_resp", REQ_W'(iresp), REQ_W'(e_iresp));
        chk("dbus_resp", REQ_W'(dresp), REQ_W'(e_dresp));
        chk("err", REQ_W'(err), REQ_W'(m_err));
        if (tidx >= 0) begin
            chk($sformatf("tbl%0d_mem_req", tidx), mreq, tbl[tidx].emreq);
            chk($sformatf("tbl%0d_ibus_resp", tidx), REQ_W'(iresp), REQ_W'(tbl[tidx].eiresp));
            chk($sformatf("tbl%0d_dbus_resp", tidx), REQ_W'(dresp), REQ_W'(tbl[tidx].edresp));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [REQ_W-1:0] NO, WR5, ir, dr;
        bit ip, dp;
        NO  = '0;
        WR5 = mkreq(1'b1, 32'h500, 32'h12345678, 4'hF);
        tbl[0]  = '{rd(32'h100), NO, rs(0,0,1), rd(32'h100), rs(0,0,1), rs(0,0,0)};
        tbl[1]  = '{NO, NO, rs(0,0,1), NO, rs(0,0,0), rs(0,0,0)};
        tbl[2]  = '{NO, NO, rs(32'hDEADBEEF,1,1), NO, rs(32'hDEADBEEF,1,0), rs(32'hDEADBEEF,0,0)};
        tbl[3]  = '{NO, NO, rs(0,0,0), NO, rs(0,0,0), rs(0,0,0)};
        tbl[4]  = '{rd(32'h200), rd(32'h300), rs(0,0,1), rd(32'h300), rs(0,0,0), rs(0,0,1)};
        tbl[5]  = '{rd(32'h200), rd(32'h304), rs(0,0,1), rd(32'h200), rs(0,0,1), rs(0,0,0)};
        tbl[6]  = '{rd(32'h204), rd(32'h304), rs(1,1,1), rd(32'h304), rs(1,0,0), rs(1,1,1)};
        tbl[7]  = '{rd(32'h204), NO, rs(2,1,1), rd(32'h204), rs(2,1,1), rs(2,0,0)};
        tbl[8]  = '{NO, NO, rs(3,1,1), NO, rs(3,0,0), rs(3,1,0)};
        tbl[9]  = '{NO, NO, rs(4,1,1), NO, rs(4,1,0), rs(4,0,0)};
        tbl[10] = '{rd(32'h400), WR5, rs(0,0,0), WR5, rs(0,0,0), rs(0,0,0)};
        tbl[11] = tbl[10];
        tbl[12] = tbl[10];
        tbl[13] = '{rd(32'h400), WR5, rs(0,0,1), WR5, rs(0,0,0), rs(0,0,1)};
        tbl[14] = '{rd(32'h400), NO, rs(0,0,1), rd(32'h400), rs(0,0,1), rs(0,0,0)};
        tbl[15] = '{NO, NO, rs(32'h55,1,0), NO, rs(32'h55,1,0), rs(32'h55,0,0)};
        tbl[16] = '{rd(32'h600), NO, rs(0,0,0), rd(32'h600), rs(0,0,0), rs(0,0,0)};
        tbl[17] = '{rd(32'h600), rd(32'h700), rs(0,0,0), rd(32'h600), rs(0,0,0), rs(0,0,0)};
        tbl[18] = '{rd(32'h600), rd(32'h700), rs(0,0,1), rd(32'h600), rs(0,0,1), rs(0,0,0)};
        tbl[19] = '{NO, rd(32'h700), rs(0,0,1), rd(32'h700), rs(0,0,0), rs(0,0,1)};
        tbl[20] = '{NO, NO, rs(7,1,0), NO, rs(7,1,0), rs(7,0,0)};
        tbl[21] = '{NO, NO, rs(8,1,0), NO, rs(8,0,0), rs(8,1,0)};

        @(posedge clk); #1;
        cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 22; k++) begin
            ireq = tbl[k].ireq; dreq = tbl[k].dreq; mresp = tbl[k].mresp;
            tidx = k;
            cycle();
        end
        tidx = -1;

        // Fill the tag FIFO, then a write passes while a read stalls until one pop.
        ireq = '0; mresp = rs(0,0,1);
        for (int k = 0; k < MAX_RD; k++) begin
            dreq = rd(32'h800 + 32'(4 * k));
            cycle();
        end
        ireq = mkreq(1'b1, 32'h900, 32'hAA, 4'h1); dreq = rd(32'h810);
        sample();
        chk("full_wr_avalid", REQ_W'(mreq[REQ_W-1]), REQ_W'(1));
        chk("full_wr_addr", REQ_W'(mreq[ADDR_LSB +: ADDR_W]), REQ_W'(32'h900));
        advance();
        ireq = '0;
        sample();
        chk("full_rd_avalid", REQ_W'(mreq[REQ_W-1]), REQ_W'(0));
        chk("full_rd_ready", REQ_W'(dresp[0]), REQ_W'(0));
        advance();
        mresp = rs(32'h11, 1, 1);
        sample();
        chk("full_no_bypass", REQ_W'(mreq[REQ_W-1]), REQ_W'(0));
        chk("full_pop_rvalid", REQ_W'(dresp[1]), REQ_W'(1));
        advance();
        mresp = rs(0, 0, 1);
        sample();
        chk("full_rd_accept_av", REQ_W'(mreq[REQ_W-1]), REQ_W'(1));
        chk("full_rd_accept_rdy", REQ_W'(dresp[0]), REQ_W'(1));
        advance();
        dreq = '0;
        for (int k = 0; k < MAX_RD; k++) begin
            mresp = rs(32'(k + 16), 1, 0);
            cycle();
        end

        // Spurious rvalid sets a sticky error; reset mid-traffic clears everything.
        mresp = rs(32'hBAD, 1, 0);
        sample();
        chk("spur_ibus_rvalid", REQ_W'(iresp[1]), REQ_W'(0));
        chk("spur_dbus_rvalid", REQ_W'(dresp[1]), REQ_W'(0));
        advance();
        mresp = '0;
        sample(); chk("err_set", REQ_W'(err), REQ_W'(1)); advance();
        cycle(); cycle();
        sample(); chk("err_sticky", REQ_W'(err), REQ_W'(1)); advance();
        ireq = rd(32'hA00); dreq = rd(32'hB00); mresp = rs(0,0,1);
        cycle(); cycle();
        ireq = mkreq(1'b1, 32'hA04, 32'h1, 4'h3); dreq = mkreq(1'b1, 32'hB04, 32'h2, 4'hC);
        rst_n = 1'b0;
        sample();
        chk("rst_mem_req", mreq, '0);
        chk("rst_ibus_ctl", REQ_W'(iresp[1:0]), REQ_W'(0));
        chk("rst_dbus_ctl", REQ_W'(dresp[1:0]), REQ_W'(0));
        advance();
        rst_n = 1'b1;
        sample();
        chk("post_rst_err", REQ_W'(err), REQ_W'(0));
        chk("post_rst_dbus_first", REQ_W'(mreq[ADDR_LSB +: ADDR_W]), REQ_W'(32'hB04));
        advance();
        ireq = '0; dreq = '0; mresp = rs(32'h77, 1, 0);
        sample();
        chk("post_rst_fifo_empty", REQ_W'({iresp[1], dresp[1]}), REQ_W'(0));
        advance();
        mresp = '0;
        sample(); chk("late_rvalid_err", REQ_W'(err), REQ_W'(1)); advance();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;

        // Random traffic: requesters hold fields until accepted, memory answers only owed reads.
        ip = 0; dp = 0; ir = '0; dr = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1;
                ir = mkreq(1'b1, $urandom, $urandom,
                           ($urandom_range(0, 1) == 0) ? '0 : STRB_W'($urandom_range(1, 15)));
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1;
                dr = mkreq(1'b1, $urandom, $urandom,
                           ($urandom_range(0, 1) == 0) ? '0 : STRB_W'($urandom_range(1, 15)));
            end
            ireq  = ip ? ir : '0;
            dreq  = dp ? dr : '0;
            cke   = ($urandom_range(0, 9) != 0);
            mresp = rs($urandom, (m_q.size() > 0) && ($urandom_range(0, 1) == 1),
                       $urandom_range(0, 3) != 0);
            sample();
            if (e_acc && !e_g) ip = 0;
            if (e_acc && e_g) dp = 0;
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
